pipediv_stream: RTL and testbench

Streaming, parametrised restoring divider, one quotient bit resolved per registered pipeline stage. It supports a valid/ready handshake on both sides with global stall, an optional signed mode, divide-by-zero flagging and a pass-through tag for reordering-free result matching. It sits between a producer issuing independent divide operations and a consumer that may back-pressure, replacing the unregistered, handshake-less divider slice chain.

---
 rtl/pipediv_pkg.sv | 16 +
 rtl/pipediv_stage.sv | 48 ++++
 rtl/pipediv_stream.sv | 109 ++++++++++
 tb/tb_pipediv_stream.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipediv_pkg.sv
// Shared width helpers for the pipelined restoring divider.
// The stage record layout itself lives next to its users because it depends on module parameters.
package pipediv_pkg;

  // Partial-remainder width: wide enough to hold |divisor| shifted by DIVIDENDLEN-1.
  function automatic int dp_width(input int dividendlen, input int divisorlen);
    return dividendlen + divisorlen - 1;
  endfunction

  // Flattened stage record: valid, tag, partial remainder, quotient, |divisor|, two signs, dbz.
  function automatic int stage_width(input int dividendlen, input int divisorlen,
                                     input int taglen);
    return 1 + taglen + dp_width(dividendlen, divisorlen) + dividendlen + divisorlen + 3;
  endfunction

endpackage

// File: rtl/pipediv_stage.sv
// One restoring-division step: compare the partial remainder against |divisor| << SHIFT,
// subtract and set quotient bit SHIFT when it fits. Purely combinational.
module pipediv_stage
  import pipediv_pkg::*;
#(
  parameter int DIVIDENDLEN = 16,
  parameter int DIVISORLEN  = 8,
  parameter int TAGLEN      = 4,
  parameter int SHIFT       = 0
) (
  input  logic [stage_width(DIVIDENDLEN, DIVISORLEN, TAGLEN)-1:0] stage_in,
  output logic [stage_width(DIVIDENDLEN, DIVISORLEN, TAGLEN)-1:0] stage_out
);

  localparam int DP = dp_width(DIVIDENDLEN, DIVISORLEN);

  // Field order must match the record declared in pipediv_stream.
  typedef struct packed {
    logic                   valid;
    logic [TAGLEN-1:0]      tag;
    logic [DP-1:0]          rem;
    logic [DIVIDENDLEN-1:0] quo;
    logic [DIVISORLEN-1:0]  dmag;
    logic                   dsign;
    logic                   vsign;
    logic                   dbz;
  } stage_t;

  stage_t        s_in;
  stage_t        s_out;
  logic [DP-1:0] shifted;

  assign s_in = stage_in;

  // NOTE: every variable driven here is given a full default first, so no path leaves it
  // unassigned and no latch is inferred; blocking '=' is correct inside always_comb.
  always_comb begin
    shifted = {{(DP-DIVISORLEN){1'b0}}, s_in.dmag} << SHIFT;
    s_out   = s_in;
    if (s_in.rem >= shifted) begin
      s_out.rem        = s_in.rem - shifted;
      s_out.quo[SHIFT] = 1'b1;
    end
  end

  assign stage_out = s_out;

endmodule

// File: rtl/pipediv_stream.sv
// Streaming restoring divider: one quotient bit per registered stage, valid/ready on both
// sides with a single global advance, optional two's-complement mode and divide-by-zero flag.
module pipediv_stream
  import pipediv_pkg::*;
#(
  parameter int DIVIDENDLEN = 16,
  parameter int DIVISORLEN  = 8,
  parameter int SIGNED      = 0,
  parameter int TAGLEN      = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DIVIDENDLEN-1:0] dividend,
  input  logic [DIVISORLEN-1:0]  divisor,
  input  logic [TAGLEN-1:0]      in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIVIDENDLEN-1:0] quotient,
  output logic [DIVISORLEN-1:0]  remainder,
  output logic [TAGLEN-1:0]      out_tag,
  output logic                   div_by_zero
);

  localparam int DP = dp_width(DIVIDENDLEN, DIVISORLEN);
  localparam int SW = stage_width(DIVIDENDLEN, DIVISORLEN, TAGLEN);

  typedef struct packed {
    logic                   valid;
    logic [TAGLEN-1:0]      tag;
    logic [DP-1:0]          rem;
    logic [DIVIDENDLEN-1:0] quo;
    logic [DIVISORLEN-1:0]  dmag;
    logic                   dsign;
    logic                   vsign;
    logic                   dbz;
  } stage_t;

  stage_t                 pipe [DIVIDENDLEN];
  logic [SW-1:0]          nxt  [DIVIDENDLEN];
  stage_t                 pre;
  stage_t                 last;
  logic [DIVIDENDLEN-1:0] dd_mag;
  logic                   adv;

  // Whole pipeline moves together; a waiting result freezes everything behind it.
  assign adv      = !pipe[DIVIDENDLEN-1].valid || out_ready;
  assign in_ready = adv;

  // Operand conditioning ahead of stage 0. On divide-by-zero the raw dividend is kept so
  // its low bits come out untouched as the remainder.
  always_comb begin
    pre       = '0;
    pre.valid = in_valid;
    pre.tag   = in_tag;
    pre.dbz   = (divisor == '0);
    pre.dsign = (SIGNED != 0) && dividend[DIVIDENDLEN-1];
    pre.vsign = (SIGNED != 0) && divisor[DIVISORLEN-1];
    pre.dmag  = pre.vsign ? -divisor : divisor;
    dd_mag    = (pre.dsign && !pre.dbz) ? -dividend : dividend;
    pre.rem   = {{(DP-DIVIDENDLEN){1'b0}}, dd_mag};
  end

  for (genvar k = 0; k < DIVIDENDLEN; k++) begin : g_stage
    logic [SW-1:0] stage_in;
    if (k == 0) begin : g_first
      assign stage_in = pre;
    end else begin : g_rest
      assign stage_in = pipe[k-1];
    end
    pipediv_stage #(
      .DIVIDENDLEN (DIVIDENDLEN),
      .DIVISORLEN  (DIVISORLEN),
      .TAGLEN      (TAGLEN),
      .SHIFT       (DIVIDENDLEN - 1 - k)
    ) u_stage (
      .stage_in  (stage_in),
      .stage_out (nxt[k])
    );
  end

  // NOTE: the stage data is cleared on reset, not just the valid bits, because the
  // output fields must read zero immediately after reset; non-blocking '<=' keeps every
  // stage sampling its predecessor's pre-edge value.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < DIVIDENDLEN; k++) pipe[k] <= '0;
    end else if (adv) begin
      for (int k = 0; k < DIVIDENDLEN; k++) pipe[k] <= stage_t'(nxt[k]);
    end
  end

  assign last        = pipe[DIVIDENDLEN-1];
  assign out_valid   = last.valid;
  assign out_tag     = last.tag;
  assign div_by_zero = last.dbz;

  // Sign fix: quotient negative when signs differ, remainder follows the dividend.
  always_comb begin
    quotient  = last.quo;
    remainder = last.rem[DIVISORLEN-1:0];
    if (!last.dbz) begin
      if (last.dsign ^ last.vsign) quotient = -last.quo;
      if (last.dsign) remainder = -last.rem[DIVISORLEN-1:0];
    end
  end

endmodule

// File: tb/tb_pipediv_stream.sv
// Scoreboard bench for pipediv_stream: an unsigned and a signed instance, expected results
// queued on acceptance from an arithmetic reference model, popped by per-instance monitors.
module tb_pipediv_stream;

  localparam int N = 16;
  localparam int M = 8;
  localparam int T = 4;

  typedef struct {
    logic [N-1:0] q;
    logic [M-1:0] r;
    logic [T-1:0] tag;
    logic         dbz;
    bit           lat;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, dbz;
  logic [N-1:0] dividend = '0, quotient;
  logic [M-1:0] divisor = '0, remainder;
  logic [T-1:0] in_tag = '0, out_tag;

  logic         s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1, s_dbz;
  logic [N-1:0] s_dividend = '0, s_quotient;
  logic [M-1:0] s_divisor = '0, s_remainder;
  logic [T-1:0] s_in_tag = '0, s_out_tag;

  exp_t u_q[$];
  exp_t s_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   ready_mode = 1'b0;
  logic [T-1:0] tag_ctr = '0;

  pipediv_stream #(.DIVIDENDLEN(N), .DIVISORLEN(M), .SIGNED(0), .TAGLEN(T)) u_dut (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder), .out_tag(out_tag),
    .div_by_zero(dbz)
  );

  pipediv_stream #(.DIVIDENDLEN(N), .DIVISORLEN(M), .SIGNED(1), .TAGLEN(T)) u_sdut (
    .clock(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .dividend(s_dividend), .divisor(s_divisor), .in_tag(s_in_tag), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .quotient(s_quotient), .remainder(s_remainder),
    .out_tag(s_out_tag), .div_by_zero(s_dbz)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    @(posedge clk); #1;
    out_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, wanted finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: plain integer division on the spec's rules.
  function automatic exp_t model_u(input logic [N-1:0] a, input logic [M-1:0] b,
                                   input logic [T-1:0] tag);
    exp_t e;
    int ia = int'(a);
    int ib = int'(b);
    e = '{q: '0, r: '0, tag: tag, dbz: 1'b0, lat: 1'b0, cyc: 0};
    if (ib == 0) begin
      e.q = '1; e.r = a[M-1:0]; e.dbz = 1'b1;
    end else begin
      e.q = N'(ia / ib); e.r = M'(ia % ib);
    end
    return e;
  endfunction

  function automatic exp_t model_s(input logic [N-1:0] a, input logic [M-1:0] b,
                                   input logic [T-1:0] tag);
    exp_t e;
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    e = '{q: '0, r: '0, tag: tag, dbz: 1'b0, lat: 1'b0, cyc: 0};
    if (sb == 0) begin
      e.q = '1; e.r = a[M-1:0]; e.dbz = 1'b1;
    end else if (sa == -(1 << (N-1)) && sb == -1) begin
      e.q = {1'b1, {(N-1){1'b0}}}; e.r = '0;
    end else begin
      e.q = N'(sa / sb); e.r = M'(sa % sb);
    end
    return e;
  endfunction

  // Starts at posedge+1 and returns at posedge+1 after the accepting edge.
  task automatic issue(input bit sgn, input logic [N-1:0] a, input logic [M-1:0] b,
                       input logic [T-1:0] tag, input bit lat);
    exp_t e;
    bit   accepted = 1'b0;
    e = sgn ? model_s(a, b, tag) : model_u(a, b, tag);
    e.lat = lat;
    if (sgn) begin
      s_in_valid = 1'b1; s_dividend = a; s_divisor = b; s_in_tag = tag;
    end else begin
      in_valid = 1'b1; dividend = a; divisor = b; in_tag = tag;
    end
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (sgn ? s_in_ready : in_ready) begin
        e.cyc = cyc;
        if (sgn) s_q.push_back(e); else u_q.push_back(e);
        accepted = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (sgn) s_in_valid = 1'b0; else in_valid = 1'b0;
    check("input accepted", 32'(accepted), 32'd1);
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (u_q.size() == 0 && s_q.size() == 0) break;
      @(posedge clk);
    end
    @(posedge clk); #1;
    check("unsigned results outstanding", u_q.size(), 0);
    check("signed results outstanding", s_q.size(), 0);
  endtask

  task automatic check_idle(input string when);
    check({when, " out_valid"}, 32'(out_valid), 32'd0);
    check({when, " in_ready"}, 32'(in_ready), 32'd1);
    check({when, " quotient"}, 32'(quotient), 32'd0);
    check({when, " remainder"}, 32'(remainder), 32'd0);
    check({when, " out_tag"}, 32'(out_tag), 32'd0);
    check({when, " div_by_zero"}, 32'(dbz), 32'd0);
    check({when, " signed out_valid"}, 32'(s_out_valid), 32'd0);
  endtask

  task automatic cmp_out(input string who, input logic [N-1:0] q, input logic [M-1:0] r,
                         input logic [T-1:0] tag, input logic z, input exp_t e);
    check({who, " quotient"}, 32'(q), 32'(e.q));
    check({who, " remainder"}, 32'(r), 32'(e.r));
    check({who, " out_tag"}, 32'(tag), 32'(e.tag));
    check({who, " div_by_zero"}, 32'(z), 32'(e.dbz));
  endtask

  // Front of queue is compared on every valid cycle, so a stalled result that changes
  // before its handshake is caught as well.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (u_q.size() == 0) begin
        check("unsigned spurious result, queue depth", u_q.size(), 1);
      end else begin
        cmp_out("unsigned", quotient, remainder, out_tag, dbz, u_q[0]);
        if (out_ready) begin
          if (u_q[0].lat) check("unsigned latency", 32'(cyc - u_q[0].cyc), 32'(N));
          void'(u_q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && s_out_valid) begin
      if (s_q.size() == 0) begin
        check("signed spurious result, queue depth", s_q.size(), 1);
      end else begin
        cmp_out("signed", s_quotient, s_remainder, s_out_tag, s_dbz, s_q[0]);
        if (s_out_ready) begin
          if (s_q[0].lat) check("signed latency", 32'(cyc - s_q[0].cyc), 32'(N));
          void'(s_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [N-1:0] a;
    logic [M-1:0] b;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("during reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle("after reset");
    @(posedge clk); #1;

    // Directed unsigned cases, including the boundary operands.
    issue(1'b0, 16'd1000, 8'd7, 4'd3, 1'b1);
    wait_drain(100);
    issue(1'b0, 16'h1234, 8'd0, 4'd4, 1'b0);
    issue(1'b0, 16'd0, 8'd255, 4'd5, 1'b0);
    issue(1'b0, 16'd254, 8'd255, 4'd6, 1'b0);
    issue(1'b0, 16'd65535, 8'd255, 4'd7, 1'b0);
    issue(1'b0, 16'd65535, 8'd1, 4'd8, 1'b0);
    wait_drain(100);

    // Signed directed cases, then a mix weighted toward the corner operands.
    issue(1'b1, 16'hFF9C, 8'd7, 4'd1, 1'b1);
    issue(1'b1, 16'h8000, 8'hFF, 4'd2, 1'b0);
    issue(1'b1, 16'hFF9C, 8'd0, 4'd3, 1'b0);
    for (int i = 0; i < 20; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 16'h8000 : N'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 8'h00;
        1:       b = 8'hFF;
        2:       b = 8'h80;
        default: b = M'($urandom);
      endcase
      issue(1'b1, a, b, T'(i), 1'b0);
    end
    wait_drain(100);

    // Back-to-back random stream against a randomly stalling consumer.
    ready_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = N'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : M'($urandom);
      issue(1'b0, a, b, tag_ctr, 1'b0);
      tag_ctr++;
    end
    wait_drain(800);
    ready_mode = 1'b0;
    @(posedge clk); #1;

    // Reset with ten operations in flight: all of them must vanish.
    for (int i = 0; i < 10; i++) issue(1'b0, N'($urandom), M'($urandom_range(1, 255)), T'(i), 1'b0);
    reset = 1'b1;
    @(posedge clk);
    u_q.delete();
    @(negedge clk);
    check_idle("mid-flight reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle("after mid-flight reset");
    @(posedge clk); #1;
    issue(1'b0, 16'd65535, 8'd1, 4'd9, 1'b1);
    wait_drain(100);
    repeat (20) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
